gray2bin_seq: RTL

//   Iterative Gray-to-binary decoder; receive-side counterpart of the bin2gray encoder.

---
 rtl/gray2bin_seq_pkg.sv | 23 ++
 rtl/gray2bin_seq_slice.sv | 25 ++
 rtl/gray2bin_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/gray2bin_seq_pkg.sv
// Shared types and a reference Gray decoder for the iterative Gray-to-binary block.
package gray2bin_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned RefWidth = 64;

  // Full-width prefix XOR; narrower words are decoded correctly when zero-extended.
  function automatic logic [RefWidth-1:0] gray2bin_ref(input logic [RefWidth-1:0] g);
    logic [RefWidth-1:0] b;
    b = '0;
    b[RefWidth-1] = g[RefWidth-1];
    for (int i = RefWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_seq_slice.sv
// Combinational decode of one STEP-bit Gray slice, MSB first, with carry in/out.
module gray2bin_seq_slice
  import gray2bin_seq_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic [STEP-1:0] i_g_slice,
  input  logic            i_carry,
  output logic [STEP-1:0] o_b_slice,
  output logic            o_carry
);

  logic w_c;

  always_comb begin
    w_c       = i_carry;
    o_b_slice = '0;
    for (int k = STEP - 1; k >= 0; k--) begin
      w_c          = w_c ^ i_g_slice[k];
      o_b_slice[k] = w_c;
    end
    o_carry = w_c;
  end

endmodule

// File: rtl/gray2bin_seq.sv
// Iterative Gray-to-binary decoder: STEP bits per cycle, MSB slice first, with
// valid/ready handshakes on both sides.
module gray2bin_seq
  import gray2bin_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             busy
);

  localparam int unsigned N    = WIDTH / STEP;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % STEP != 0) begin : g_bad_step
    $error("gray2bin_seq: WIDTH must be a multiple of STEP");
  end

  state_e             r_state;
  logic [WIDTH-1:0]   r_gray;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_bin;
  logic               r_carry;
  logic [IdxW-1:0]    r_idx;
  logic               r_out_valid;
  logic               r_busy;

  logic [STEP-1:0]    w_g_slice;
  logic [STEP-1:0]    w_b_slice;
  logic               w_carry;
  logic [WIDTH-1:0]   w_work_next;
  logic               w_accept;
  logic               w_last;

  assign in_ready  = (r_state == StIdle) & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_idx == '0);
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign bin_out   = r_bin;

  always_comb begin
    w_g_slice = r_gray[r_idx*STEP +: STEP];
  end

  gray2bin_seq_slice #(
    .STEP (STEP)
  ) u_slice (
    .i_g_slice (w_g_slice),
    .i_carry   (r_carry),
    .o_b_slice (w_b_slice),
    .o_carry   (w_carry)
  );

  always_comb begin
    w_work_next                     = r_work;
    w_work_next[r_idx*STEP +: STEP] = w_b_slice;
  end

  // r_bin only updates on completion so bin_out keeps the last result in IDLE/BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_gray      <= '0;
      r_work      <= '0;
      r_bin       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_gray  <= gray_in;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_idx   <= IdxW'(N - 1);
            r_busy  <= 1'b1;
            r_state <= StBusy;
          end
        end
        StBusy: begin
          r_work  <= w_work_next;
          r_carry <= w_carry;
          if (w_last) begin
            r_bin       <= w_work_next;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

endmodule
